// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, synchronized row sensing, press/release debounce.
// Optional autorepeat while a key is held is enabled with `define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       newkey,
  output logic [4:0] keycode
);

  // state      | meaning
  // SCAN       | rotate the low column, watch for any low row
  // PRESS_DB   | column frozen, latched key must stay lowest-low row
  // HELD       | key accepted, keycode valid, waiting for release
  // RELEASE_DB | latched row high, must stay high to complete release
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam int MAX_A   = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAX_CNT = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_TC   = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
`endif

  state_t        state_q, state_d;
  logic [3:0]    row_meta_q, row_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic          newkey_q, newkey_d;
  logic [4:0]    keycode_q, keycode_d;

  logic [3:0] row_low;
  logic [1:0] low_idx;
  logic       latched_low;
  logic       pressed_same;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      state_q    <= SCAN;
      cnt_q      <= '0;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      newkey_q   <= 1'b0;
      keycode_q  <= 5'b00000;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      newkey_q   <= newkey_d;
      keycode_q  <= keycode_d;
    end
  end

  assign row_low = ~row_sync_q;

  always_comb begin
    low_idx = 2'd3;
    if (row_low[0])      low_idx = 2'd0;
    else if (row_low[1]) low_idx = 2'd1;
    else if (row_low[2]) low_idx = 2'd2;
  end

  assign latched_low  = row_low[row_idx_q];
  // A second key on a lower-index row changes the winner, so it aborts the press.
  assign pressed_same = latched_low && (low_idx == row_idx_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    newkey_d  = 1'b0;
    keycode_d = keycode_q;
    case (state_q)
      SCAN: begin
        if (|row_low) begin
          row_idx_d = low_idx;
          cnt_d     = '0;
          state_d   = PRESS_DB;
        end else if (cnt_q == SCAN_TC) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESS_DB: begin
        if (!pressed_same) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (cnt_q == DB_TC) begin
          cnt_d     = '0;
          newkey_d  = 1'b1;
          keycode_d = {1'b1, row_idx_q, col_idx_q};
          state_d   = HELD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!latched_low) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (cnt_q == REPEAT_TC) begin
          cnt_d    = '0;
          newkey_d = !newkey_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RELEASE_DB: begin
        if (latched_low) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == DB_TC) begin
          cnt_d        = '0;
          keycode_d[4] = 1'b0;
          state_d      = SCAN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  assign col     = ~(4'b0001 << col_idx_q);
  assign newkey  = newkey_q;
  assign keycode = keycode_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32.
// Cycle numbers count rising edges after reset release (edge 1 is the first).
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic       newkey;
  logic [4:0] keycode;
  logic [15:0] press = 16'h0000;   // bit r*4+c = key at row r, column c

  int checks = 0;
  int errors = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(32)) dut (
    .clock(clock), .reset(reset), .row(row), .col(col), .newkey(newkey), .keycode(keycode)
  );

  always #5 clock = ~clock;

  // Switch matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    int          cidx;
    logic [4:0]  code;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] one;
    one = 4'b0001 << c;
    return ~one;
  endfunction

  initial begin
    int first, second, pulses, expc;

    vecs[0] = '{16'h0400, 2, 5'b11010};  // row 2, col 2
    vecs[1] = '{16'h0001, 0, 5'b10000};  // row 0, col 0
    vecs[2] = '{16'h8000, 3, 5'b11111};  // row 3, col 3
    vecs[3] = '{16'h1010, 0, 5'b10100};  // rows 1 and 3 on col 0, row 1 wins
    vecs[4] = '{16'h0008, 3, 5'b10011};  // row 0, col 3

    // Reset values
    press = 16'h0000;
    reset = 1'b0;
    step();
    check("reset_col", int'(col), int'(4'b1110));
    check("reset_newkey", int'(newkey), 0);
    check("reset_keycode", int'(keycode), 0);

    // Idle scanning
    do_reset();
    pulses = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (newkey) pulses++;
      if (n % 4 == 0 || n % 4 == 1) check("scan_col", int'(col), int'(col_of((n / 4) % 4)));
    end
    check("scan_no_newkey", pulses, 0);

    // Table: key held through reset, accepted at edge 4*col+11, then released
    for (int v = 0; v < 5; v++) begin
      press = vecs[v].keys;
      do_reset();
      expc = 4 * vecs[v].cidx + 11;
      first = -1;
      pulses = 0;
      for (int n = 1; n <= expc + 20; n++) begin
        step();
        if (newkey) begin
          pulses++;
          if (first < 0) first = n;
        end
        if (n == expc + 5) check("held_col_frozen", int'(col), int'(col_of(vecs[v].cidx)));
      end
      check("press_latency", first, expc);
      check("press_pulses", pulses, 1);
      check("press_keycode", int'(keycode), int'(vecs[v].code));
      press = 16'h0000;
      pulses = 0;
      for (int m = 1; m <= 11; m++) begin
        step();
        if (newkey) pulses++;
        if (m == 10) check("release_pending", int'(keycode), int'(vecs[v].code));
        if (m == 11) check("release_keycode", int'(keycode), int'({1'b0, vecs[v].code[3:0]}));
      end
      check("release_no_newkey", pulses, 0);
    end

    // Short glitch on row 1 / col 1: no acceptance, scanning resumes at col 2
    press = 16'h0000;
    do_reset();
    repeat (4) step();
    press = 16'h0020;
    pulses = 0;
    for (int n = 5; n <= 40; n++) begin
      step();
      if (n == 7) press = 16'h0000;
      if (newkey) pulses++;
      if (n == 8)  check("glitch_col_frozen", int'(col), int'(4'b1101));
      if (n == 10) check("glitch_resume_col", int'(col), int'(4'b1011));
      if (n == 13) check("glitch_col_hold", int'(col), int'(4'b1011));
      if (n == 14) check("glitch_col_next", int'(col), int'(4'b0111));
    end
    check("glitch_no_newkey", pulses, 0);

    // Release bounce: one-cycle re-press during release debounce returns to HELD
    press = 16'h0400;
    do_reset();
    pulses = 0;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (newkey) pulses++;
    end
    check("bounce_first_pulse", pulses, 1);
    press = 16'h0000;
    pulses = 0;
    for (int n = 26; n <= 50; n++) begin
      step();
      if (n == 29) press = 16'h0400;
      if (n == 30) press = 16'h0000;
      if (newkey) pulses++;
      if (n == 40) check("bounce_still_held", int'(keycode), int'(5'b11010));
      if (n == 41) check("bounce_released", int'(keycode), int'(5'b01010));
    end
    check("bounce_no_newkey", pulses, 0);

    // Long hold, then reset asserted while HELD
    press = 16'h0400;
    do_reset();
    pulses = 0;
    first = -1;
    second = -1;
    for (int n = 1; n <= 130; n++) begin
      step();
      if (newkey) begin
        pulses++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    check("hold_first_pulse", first, 19);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_pulses", pulses, 4);
    check("hold_repeat_at", second, 51);
`else
    check("hold_pulses", pulses, 1);
    check("hold_no_repeat", second, -1);
`endif
    check("hold_keycode", int'(keycode), int'(5'b11010));
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_col", int'(col), int'(4'b1110));
    check("async_reset_keycode", int'(keycode), 0);
    check("async_reset_newkey", int'(newkey), 0);
    press = 16'h0000;
    step();
    step();
    reset = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (newkey) pulses++;
      if (n == 3) check("post_reset_col0", int'(col), int'(4'b1110));
      if (n == 4) check("post_reset_col1", int'(col), int'(4'b1101));
    end
    check("post_reset_no_newkey", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven during scanning.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 20000: cycles a press or release must be stable before it is accepted.
REQ-003 The module SHALL have parameter REPEAT_CYCLES, default 5000000: autorepeat interval, used only under KEYPAD_AUTOREPEAT_EN.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to clock.
REQ-007 The module SHALL have port col, output, 4 bits: keypad column drives, active-low, at most one bit low at any time.
REQ-008 The module SHALL have port newkey, output, 1 bit: high for exactly one cycle per accepted keypress.
REQ-009 The module SHALL have port keycode, output, 5 bits: bit 4 high while a key is held; bits 3:2 give the row index; bits 1:0 give the column index.

Function
REQ-010 The row input SHALL pass through a two-flop synchronizer; all decisions use only the synchronized value (2-cycle input latency).
REQ-011 The state machine SHALL have states SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-012 In SCAN, col SHALL drive one column low, advancing 0->1->2->3->0 every SCAN_DIV cycles (counter wraps at SCAN_DIV-1).
REQ-013 In SCAN, any synchronized row bit low SHALL latch the current column and the lowest-index low row, freeze col, and enter PRESS_DB.
REQ-014 In PRESS_DB, if the latched row/column stays pressed for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL enter HELD, pulse newkey for one cycle, and load keycode with {1, row, col} in that same cycle.
REQ-015 In PRESS_DB, a release or change of the lowest low row before the count completes SHALL return the FSM to SCAN, resume scanning at the next column, and produce no newkey.
REQ-016 In HELD, col SHALL stay frozen and keycode SHALL stay constant; additional rows going low SHALL be ignored.
REQ-017 In HELD, the latched row going high SHALL enter RELEASE_DB.
REQ-018 In RELEASE_DB, DEBOUNCE_CYCLES consecutive released cycles SHALL clear keycode[4], keep keycode[3:0], and return to SCAN.
REQ-019 In RELEASE_DB, the latched row going low again SHALL return to HELD with no newkey.
REQ-020 newkey SHALL be registered and SHALL never be high in two consecutive cycles.
REQ-021 Counters SHALL be sized to hold max(SCAN_DIV, DEBOUNCE_CYCLES, REPEAT_CYCLES) and SHALL clear on every state transition.

Reset
REQ-022 On reset low, the FSM SHALL go to SCAN immediately, asynchronously; col=4'b1110, newkey=0, keycode=5'b00000, and all counters and synchronizer flops SHALL be 0 (synchronizer 4'b1111).
REQ-023 Reset asserted mid-press, in any state, SHALL abandon the press; after release the FSM SHALL scan from column 0 with no newkey until a fresh full debounce.

Configuration
REQ-024 When KEYPAD_AUTOREPEAT_EN is defined, in HELD the module SHALL pulse newkey again every REPEAT_CYCLES cycles, with keycode unchanged.
REQ-025 When KEYPAD_AUTOREPEAT_EN is undefined, the module SHALL produce exactly one newkey per press and SHALL synthesize no repeat counter logic.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32)
REQ-026 Reset release, no key -> col cycles 1110,1101,1011,0111 every 4 cycles; newkey stays 0.
REQ-027 Row 2 held low while col=1011 (col 2), stable -> one newkey pulse 8 cycles after PRESS_DB entry plus synchronizer delay; keycode=5'b11010.
REQ-028 Row 1 low for 3 cycles then high -> no newkey; scanning resumes at the next column.
REQ-029 Press accepted, then release bouncing 1 cycle in RELEASE_DB -> returns to HELD, no second newkey; after a clean 8-cycle release, keycode[4]=0 and keycode[3:0] is kept.
REQ-030 Rows 1 and 3 low together on col 0 -> keycode=5'b10100 (row 1 wins).
REQ-031 Key held for 100 cycles: with KEYPAD_AUTOREPEAT_EN -> newkey pulses at acceptance and every 32 cycles afterwards; without it -> exactly one pulse; reset low mid-HELD -> col=1110 and keycode=0 asynchronously.
